// File: rtl/key_loader_if.sv
// key_loader_if: host-side load request plus key register bus, with readback lines.
interface key_loader_if #(parameter int MAX_KEYS = 4, parameter int KEY_W = 8);
    logic                      start;
    logic [2:0]                key_cnt;
    logic [MAX_KEYS*KEY_W-1:0] key_data;
    logic [2:0]                kr_num_keys;
    logic [MAX_KEYS*KEY_W-1:0] kr_keys;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic                      kreset;
    logic [KEY_W-1:0]          kdout;
    logic                      kwr;
    logic                      kset;
    modport master(output start, key_cnt, key_data, kr_num_keys, kr_keys,
                   input busy, done, err, kreset, kdout, kwr, kset);
    modport slave(input start, key_cnt, key_data, kr_num_keys, kr_keys,
                  output busy, done, err, kreset, kdout, kwr, kset);
endinterface

// File: rtl/key_loader.sv
// key_loader: clears the key register, streams up to MAX_KEYS keys, then latches them.
// Define KEY_LOADER_READBACK_EN to add a VERIFY cycle that checks the register readback.
module key_loader #(
    parameter int MAX_KEYS = 4,
    parameter int KEY_W    = 8
) (
    input logic dclk,
    input logic reset,
    key_loader_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLR    = 3'd1;
    localparam logic [2:0] SEND   = 3'd2;
    localparam logic [2:0] LATCH  = 3'd3;
    localparam logic [2:0] VERIFY = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] MAX_CNT = 3'(MAX_KEYS);
    localparam int DW = MAX_KEYS * KEY_W;
    logic [2:0]       state;
    logic [2:0]       cnt;
    logic [2:0]       idx;
    logic [2:0]       nxt;
    logic [DW-1:0]    kd;
    logic [KEY_W-1:0] key;
    logic             bad;
    assign bad = bus.key_cnt == 3'd0 || bus.key_cnt > MAX_CNT;
    assign nxt = idx + 3'd1;
    assign key = kd[nxt*KEY_W +: KEY_W];
`ifdef KEY_LOADER_READBACK_EN
    logic [DW-1:0] mask;
    logic          mism;
    // only the low cnt keys of the readback are meaningful
    assign mask = ~({DW{1'b1}} << (cnt * KEY_W));
    assign mism = bus.kr_num_keys != cnt || ((bus.kr_keys ^ kd) & mask) != '0;
`endif
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            kd         <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
            bus.kreset <= 1'b0;
            bus.kwr    <= 1'b0;
            bus.kset   <= 1'b0;
            bus.kdout  <= '0;
        end else begin
            bus.done   <= 1'b0;
            bus.kreset <= 1'b0;
            bus.kset   <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    cnt        <= bus.key_cnt;
                    kd         <= bus.key_data;
                    idx        <= '0;
                    bus.busy   <= 1'b1;
                    bus.err    <= bad;
                    bus.done   <= bad;
                    bus.kreset <= !bad;
                    state      <= bad ? DONE : CLR;
                end
                CLR: begin
                    bus.kwr   <= 1'b1;
                    bus.kdout <= kd[KEY_W-1:0];
                    state     <= SEND;
                end
                SEND: if (idx == cnt - 3'd1) begin
                    bus.kwr   <= 1'b0;
                    bus.kdout <= '0;
                    bus.kset  <= 1'b1;
                    state     <= LATCH;
                end else begin
                    idx       <= nxt;
                    bus.kdout <= key;
                end
`ifdef KEY_LOADER_READBACK_EN
                LATCH: state <= VERIFY;
                VERIFY: begin
                    bus.err  <= mism;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
`else
                LATCH: begin
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
`endif
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: table vectors, hand-written corner sequences and random loads vs a trace model.
module tb_key_loader;
`ifdef KEY_LOADER_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    logic dclk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    key_loader_if bus();
    key_loader dut(.dclk(dclk), .reset(reset), .bus(bus));
    always #5 dclk = ~dclk;
    typedef struct {
        logic [2:0]  n;
        logic [31:0] d;
        logic        exp_err;
        int          exp_win;
    } vec_t;
    vec_t vt[7];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask
    function automatic bit valid_n(input logic [2:0] n);
        return n >= 3'd1 && n <= 3'd4;
    endfunction
    function automatic bit model_err(input logic [2:0] n, input logic [31:0] d,
                                     input logic [2:0] krn, input logic [31:0] krk);
        if (!valid_n(n)) return 1'b1;
        if (RB == 0) return 1'b0;
        if (krn != n) return 1'b1;
        for (int i = 0; i < int'(n); i++)
            if (d[8*i +: 8] != krk[8*i +: 8]) return 1'b1;
        return 1'b0;
    endfunction
    function automatic int model_win(input logic [2:0] n);
        return valid_n(n) ? int'(n) + 3 + RB : 1;
    endfunction
    // Window j spans edges E(j-1)..E(j) after the accepting edge E0.
    task automatic run_load(input string nm, input logic [2:0] n, input logic [31:0] d,
                            input logic [2:0] krn, input logic [31:0] krk,
                            input logic exp_err, input int exp_win,
                            input bit disturb, input bit chain,
                            input logic [2:0] n2, input logic [31:0] d2, input bit pre);
        logic [7:0] got[$];
        int done_win = 0, kr_win = 0, ks_win = 0, kr_cnt = 0, ks_cnt = 0;
        int busy_bad = 0, multi = 0, dout_bad = 0;
        logic err_obs = 1'bx;
        bit v = valid_n(n);
        bus.key_cnt = n; bus.key_data = d; bus.kr_num_keys = krn; bus.kr_keys = krk;
        bus.start = 1'b1;
        if (pre) begin
            @(negedge dclk);
            chk({nm, "_idle_busy"}, bus.busy, 0);
        end
        for (int j = 1; j <= 20 && done_win == 0; j++) begin
            @(negedge dclk);
            if (j == 1) bus.start = 1'b0;
            if (disturb && j == 3) begin
                bus.start = 1'b1; bus.key_data = ~d; bus.key_cnt = 3'd1;
            end
            if (disturb && j == 4) bus.start = 1'b0;
            if (bus.kreset) begin kr_cnt++; kr_win = j; end
            if (bus.kset) begin ks_cnt++; ks_win = j; end
            if (bus.kwr) got.push_back(bus.kdout);
            else if (bus.kdout != 8'h00) dout_bad++;
            if (!bus.busy) busy_bad++;
            if (int'(bus.kreset) + int'(bus.kwr) + int'(bus.kset) > 1) multi++;
            if (bus.done) begin
                done_win = j;
                err_obs = bus.err;
                if (chain) begin
                    bus.key_cnt = n2; bus.key_data = d2; bus.start = 1'b1;
                end
            end
        end
        chk({nm, "_done_win"}, done_win, exp_win);
        chk({nm, "_err"}, err_obs, exp_err);
        chk({nm, "_kreset_win"}, kr_cnt * 100 + kr_win, v ? 101 : 0);
        chk({nm, "_kset_win"}, ks_cnt * 100 + ks_win, v ? 100 + int'(n) + 2 : 0);
        chk({nm, "_nbytes"}, got.size(), v ? int'(n) : 0);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk($sformatf("%s_byte%0d", nm, i), got[i], 32'(d >> (8 * i)) & 32'hFF);
        chk({nm, "_busy_hold"}, busy_bad, 0);
        chk({nm, "_onehot"}, multi, 0);
        chk({nm, "_kdout_idle0"}, dout_bad, 0);
        if (!chain) begin
            @(negedge dclk);
            chk({nm, "_after"}, {bus.busy, bus.done}, 0);
        end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic [2:0]  n, krn;
        logic [31:0] d, krk;
        int          ks;
        vt[0] = '{3'd4, 32'h1E0E0602, 1'b0, 7 + RB};
        vt[1] = '{3'd1, 32'hFFFFFFAA, 1'b0, 4 + RB};
        vt[2] = '{3'd0, 32'h12345678, 1'b1, 1};
        vt[3] = '{3'd5, 32'h87654321, 1'b1, 1};
        vt[4] = '{3'd2, 32'hCAFE5A3C, 1'b0, 5 + RB};
        vt[5] = '{3'd3, 32'h00C3B2A1, 1'b0, 6 + RB};
        vt[6] = '{3'd7, 32'hDEADBEEF, 1'b1, 1};
        reset = 1'b1;
        bus.start = 1'b0; bus.key_cnt = '0; bus.key_data = '0;
        bus.kr_num_keys = '0; bus.kr_keys = '0;
        repeat (3) @(negedge dclk);
        chk("reset_outs", {bus.busy, bus.done, bus.err, bus.kreset, bus.kwr, bus.kset, bus.kdout}, 0);
        reset = 1'b0;
        @(negedge dclk);
        chk("idle_outs", {bus.busy, bus.done, bus.err, bus.kreset, bus.kwr, bus.kset, bus.kdout}, 0);
        foreach (vt[i])
            run_load($sformatf("vec%0d", i), vt[i].n, vt[i].d, vt[i].n, vt[i].d,
                     vt[i].exp_err, vt[i].exp_win, 0, 0, 0, 0, 0);
        // start and data wiggled mid-load, then a back-to-back request during done
        run_load("dist", 3'd4, 32'hA1B2C3D4, 3'd4, 32'hA1B2C3D4, 1'b0, 7 + RB,
                 1, 1, 3'd3, 32'h00554433, 0);
        run_load("b2b", 3'd3, 32'h00554433, 3'd3, 32'h00554433, 1'b0, 6 + RB,
                 0, 0, 0, 0, 1);
        // asynchronous reset during the second key byte
        bus.key_cnt = 3'd4; bus.key_data = 32'h44332211;
        bus.kr_num_keys = 3'd4; bus.kr_keys = 32'h44332211; bus.start = 1'b1;
        @(negedge dclk); bus.start = 1'b0;
        @(negedge dclk);
        @(negedge dclk);
        chk("rst_mid_kwr", {bus.kwr, bus.kdout}, 9'h122);
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", {bus.busy, bus.done, bus.err, bus.kreset, bus.kwr, bus.kset, bus.kdout}, 0);
        @(negedge dclk); reset = 1'b0;
        ks = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge dclk);
            if (bus.kset || bus.busy) ks++;
        end
        chk("rst_no_kset", ks, 0);
        run_load("post_rst", 3'd4, 32'h0BADF00D, 3'd4, 32'h0BADF00D, 1'b0, 7 + RB, 0, 0, 0, 0, 0);
`ifdef KEY_LOADER_READBACK_EN
        run_load("rb_ok", 3'd2, 32'h1234BEEF, 3'd2, 32'hFFFFBEEF, 1'b0, 6, 0, 0, 0, 0, 0);
        run_load("rb_bad", 3'd2, 32'h1234BEEF, 3'd2, 32'hFFFFAAEF, 1'b1, 6, 0, 0, 0, 0, 0);
        run_load("rb_cnt", 3'd2, 32'h1234BEEF, 3'd3, 32'h1234BEEF, 1'b1, 6, 0, 0, 0, 0, 0);
`endif
        for (int r = 0; r < 40; r++) begin
            n = 3'($urandom_range(0, 7));
            d = $urandom;
            krn = n;
            krk = d;
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) krn = 3'($urandom_range(0, 7));
                else krk = krk ^ (32'h1 << $urandom_range(0, 31));
            end
            run_load($sformatf("rnd%0d", r), n, d, krn, krk, model_err(n, d, krn, krk),
                     model_win(n), 0, 0, 0, 0, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
